// File: rtl/pong_game_engine.sv
// Frame-rate Pong engine: ball, paddles, score and game FSM advance once per vsync fall.
// Build macro PONG_AI_RIGHT_EN makes the right paddle track the ball instead of its buttons.
module pong_game_engine #(
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 60,
  parameter int WIN_POINTS   = 9
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iVS,
  input  logic       btn_start,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [8:0] paddle_left_y,
  output logic [8:0] paddle_right_y,
  output logic [7:0] score,
  output logic [2:0] game_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam logic [9:0]         CX         = 10'd315;
  localparam logic [9:0]         CY         = 10'd235;
  localparam logic [8:0]         PAD_RST    = 9'd220;
  localparam logic [8:0]         PAD_MAX    = 9'd440;
  localparam logic [8:0]         PAD_STEP   = 9'(PADDLE_SPEED);
  localparam logic [9:0]         BSTEP10    = 10'(BALL_SPEED);
  localparam logic signed [11:0] BSTEP      = 12'(BALL_SPEED);
  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0]         WIN        = 4'(WIN_POINTS);

  // Button bit order: {start, l_up, l_dn, r_up, r_dn}
  logic [4:0] sync1, sync2;
  logic       start_d, start_pend, vs_d, tick;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] l_pts, r_pts, l_n, r_n;
  logic       dx_pos, dy_pos, serve_right, dx_n, dy_n, srv_n;
  logic [9:0] bx_n, by_n;
  logic [8:0] pl_n, pr_n;
  logic [7:0] score_n;

  logic signed [11:0] bx_s, by_s, pl_s, pr_s, nx, ny;
  logic ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r, win;

  assign tick = vs_d & ~iVS;

  // A start edge is remembered until the next tick, which then consumes it in any state.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1      <= '0;
      sync2      <= '0;
      start_d    <= 1'b0;
      start_pend <= 1'b0;
      vs_d       <= 1'b0;
    end else begin
      sync1   <= {btn_start, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn};
      sync2   <= sync1;
      start_d <= sync2[4];
      vs_d    <= iVS;
      if (sync2[4] && !start_d) start_pend <= 1'b1;
      else if (tick)            start_pend <= 1'b0;
    end
  end

  assign bx_s   = $signed({2'b00, ball_x});
  assign by_s   = $signed({2'b00, ball_y});
  assign pl_s   = $signed({3'b000, paddle_left_y});
  assign pr_s   = $signed({3'b000, paddle_right_y});
  assign nx     = dx_pos ? bx_s + BSTEP : bx_s - BSTEP;
  assign ny     = dy_pos ? by_s + BSTEP : by_s - BSTEP;
  assign ovl_l  = (by_s + 12'sd10 > pl_s) && (by_s < pl_s + 12'sd40);
  assign ovl_r  = (by_s + 12'sd10 > pr_s) && (by_s < pr_s + 12'sd40);
  assign hit_l  = !dx_pos && (nx <= 12'sd30) && (nx + 12'sd10 > 12'sd20) && ovl_l;
  assign hit_r  = dx_pos && (nx + 12'sd10 >= 12'sd610) && (nx < 12'sd620) && ovl_r;
  assign miss_l = (nx <= 12'sd0);
  assign miss_r = (nx >= 12'sd630);
  assign win    = (l_pts == WIN) || (r_pts == WIN);

`ifdef PONG_AI_RIGHT_EN
  localparam logic [8:0] AI_STEP = 9'(PADDLE_SPEED / 2);
  logic [10:0] ball_c, pad_c;
  logic        ai_up, ai_dn;
  assign ball_c = {1'b0, ball_y} + 11'd5;
  assign pad_c  = {2'b00, paddle_right_y} + 11'd20;
  assign ai_dn  = ball_c > pad_c + 11'd2;
  assign ai_up  = ball_c + 11'd2 < pad_c;
`endif

  function automatic logic [8:0] paddle_step(input logic [8:0] p, input logic up,
                                             input logic dn, input logic [8:0] amt);
    logic [9:0] sum;
    sum = {1'b0, p} + {1'b0, amt};
    if (up && !dn) return (p < amt) ? 9'd0 : p - amt;
    if (dn && !up) return (sum > {1'b0, PAD_MAX}) ? PAD_MAX : sum[8:0];
    return p;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] p);
    return (p < WIN) ? p + 4'd1 : p;
  endfunction

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)   state <= S_IDLE;
    else if (tick) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (start_pend) state_n = S_SERVE;
      S_SERVE:    if (cnt == SERVE_LAST) state_n = S_PLAY;
      S_PLAY:     if (miss_l || miss_r) state_n = S_POINT;
      S_POINT:    if (cnt == POINT_LAST) state_n = win ? S_GAMEOVER : S_SERVE;
      S_GAMEOVER: if (start_pend) state_n = S_SERVE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    game_state = state;
  end

  always_comb begin
    bx_n  = ball_x;
    by_n  = ball_y;
    dx_n  = dx_pos;
    dy_n  = dy_pos;
    srv_n = serve_right;
    l_n   = l_pts;
    r_n   = r_pts;
    pl_n  = paddle_left_y;
    pr_n  = paddle_right_y;
    cnt_n = (state_n != state) ? 8'd0 : cnt + 8'd1;
    case (state)
      S_IDLE: if (start_pend) begin
        l_n = 4'd0; r_n = 4'd0; srv_n = 1'b1; bx_n = CX; by_n = CY;
      end
      // The launch tick already takes the first step so the ball leaves centre with the state change.
      S_SERVE: begin
        bx_n = CX;
        by_n = CY;
        if (state_n == S_PLAY) begin
          dx_n = serve_right;
          dy_n = 1'b1;
          bx_n = serve_right ? CX + BSTEP10 : CX - BSTEP10;
          by_n = CY + BSTEP10;
        end
      end
      S_PLAY: begin
        if (ny <= 12'sd0) begin
          by_n = 10'd0;   dy_n = 1'b1;
        end else if (ny >= 12'sd470) begin
          by_n = 10'd470; dy_n = 1'b0;
        end else begin
          by_n = ny[9:0];
        end
        if (miss_l) begin
          bx_n = 10'd0;   r_n = sat_inc(r_pts); srv_n = 1'b0;
        end else if (miss_r) begin
          bx_n = 10'd630; l_n = sat_inc(l_pts); srv_n = 1'b1;
        end else if (hit_l) begin
          bx_n = 10'd30;  dx_n = 1'b1;
        end else if (hit_r) begin
          bx_n = 10'd600; dx_n = 1'b0;
        end else begin
          bx_n = nx[9:0];
        end
      end
      S_POINT: if (state_n == S_SERVE) begin
        bx_n = CX; by_n = CY;
      end
      S_GAMEOVER: if (start_pend) begin
        l_n = 4'd0; r_n = 4'd0; bx_n = CX; by_n = CY;
      end
      default: ;
    endcase
    if (state == S_SERVE || state == S_PLAY) begin
      pl_n = paddle_step(paddle_left_y, sync2[3], sync2[2], PAD_STEP);
`ifdef PONG_AI_RIGHT_EN
      pr_n = paddle_step(paddle_right_y, ai_up, ai_dn, AI_STEP);
`else
      pr_n = paddle_step(paddle_right_y, sync2[1], sync2[0], PAD_STEP);
`endif
    end
    score_n = ({4'b0000, l_n} * 8'd10) + {4'b0000, r_n};
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ball_x         <= CX;
      ball_y         <= CY;
      paddle_left_y  <= PAD_RST;
      paddle_right_y <= PAD_RST;
      score          <= 8'd0;
      dx_pos         <= 1'b1;
      dy_pos         <= 1'b1;
      serve_right    <= 1'b1;
      l_pts          <= 4'd0;
      r_pts          <= 4'd0;
      cnt            <= 8'd0;
    end else if (tick) begin
      ball_x         <= bx_n;
      ball_y         <= by_n;
      paddle_left_y  <= pl_n;
      paddle_right_y <= pr_n;
      score          <= score_n;
      dx_pos         <= dx_n;
      dy_pos         <= dy_n;
      serve_right    <= srv_n;
      l_pts          <= l_n;
      r_pts          <= r_n;
      cnt            <= cnt_n;
    end
  end

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: one vsync fall per frame task, trajectories hand-computed.
module tb_pong_game_engine;

  logic       iVGA_CLK = 1'b0;
  logic       iRST_n   = 1'b0;
  logic       iVS      = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic [8:0] paddle_left_y, paddle_right_y;
  logic [7:0] score;
  logic [2:0] game_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iVGA_CLK = ~iVGA_CLK;

  pong_game_engine dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iVS(iVS), .btn_start(btn_start),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_left_y(paddle_left_y),
    .paddle_right_y(paddle_right_y), .score(score), .game_state(game_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(ball_x), 32'(x));
    check({tag, "_y"}, 32'(ball_y), 32'(y));
  endtask

  task automatic settle();
    repeat (3) @(negedge iVGA_CLK);
  endtask

  // One video frame: a single-clock low pulse on iVS gives exactly one tick.
  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iVGA_CLK) iVS = 1'b0;
      @(negedge iVGA_CLK) iVS = 1'b1;
      repeat (3) @(negedge iVGA_CLK);
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    repeat (4) @(negedge iVGA_CLK);
    btn_start = 1'b0;
    settle();
  endtask

  initial begin
    // Reset values while reset is held
    repeat (2) @(negedge iVGA_CLK);
    check_ball("rst_ball", 315, 235);
    check("rst_pl", 32'(paddle_left_y), 220);
    check("rst_pr", 32'(paddle_right_y), 220);
    check("rst_score", 32'(score), 0);
    check("rst_state", 32'(game_state), 0);
    iRST_n = 1'b1;
    settle();
    run_frames(1);
    check("idle_state", 32'(game_state), 0);
    check_ball("idle_ball", 315, 235);

    press_start();
    run_frames(1);
    check("serve_state", 32'(game_state), 1);
    check_ball("serve_ball", 315, 235);

    // Serve: left paddle up to the top clamp, right paddle down to 420
    btn_l_up = 1'b1; btn_r_dn = 1'b1;
    settle();
    run_frames(50);
    check("pl_after50", 32'(paddle_left_y), 20);
    check("pr_after50", 32'(paddle_right_y), 420);
    btn_r_dn = 1'b0;
    settle();
    run_frames(9);
    check("serve59_state", 32'(game_state), 1);
    check("pl_clamp0", 32'(paddle_left_y), 0);
    check_ball("serve59_ball", 315, 235);
    run_frames(1);
    check("launch_state", 32'(game_state), 2);
    check_ball("launch_ball", 317, 237);
    check("pl_stay0", 32'(paddle_left_y), 0);
    check("pr_hold", 32'(paddle_right_y), 420);

    btn_l_up = 1'b0; btn_l_dn = 1'b1;
    settle();
    run_frames(10);
    check("pl_down40", 32'(paddle_left_y), 40);
    check_ball("j10_ball", 337, 257);
    btn_l_up = 1'b1;
    settle();
    run_frames(5);
    check("pl_both_still", 32'(paddle_left_y), 40);
    check_ball("j15_ball", 347, 267);
    btn_l_up = 1'b0; btn_l_dn = 1'b0;
    settle();

    // Floor bounce, right paddle hit, ceiling bounce, left miss
    run_frames(101);
    check_ball("j116_ball", 549, 469);
    run_frames(1);
    check_ball("floor_ball", 551, 470);
    run_frames(1);
    check_ball("floor_next", 553, 468);
    run_frames(23);
    check_ball("j141_ball", 599, 422);
    run_frames(1);
    check_ball("rhit_ball", 600, 420);
    check("rhit_state", 32'(game_state), 2);
    run_frames(1);
    check_ball("rhit_next", 598, 418);
    run_frames(208);
    check_ball("m209_ball", 182, 2);
    run_frames(1);
    check_ball("ceil_ball", 180, 0);
    run_frames(1);
    check_ball("ceil_next", 178, 2);
    run_frames(88);
    check_ball("m299_ball", 2, 178);
    check("m299_state", 32'(game_state), 2);
    run_frames(1);
    check("lmiss_state", 32'(game_state), 3);
    check("lmiss_score", 32'(score), 1);
    run_frames(59);
    check("point59_state", 32'(game_state), 3);
    check("point59_score", 32'(score), 1);
    run_frames(1);
    check("reserve_state", 32'(game_state), 1);
    check_ball("reserve_ball", 315, 235);

    // Serves now go left; the left paddle at 40 misses every rally
    for (int r = 2; r <= 9; r++) begin
      run_frames(60);
      check("rally_launch_state", 32'(game_state), 2);
      check_ball("rally_launch_ball", 313, 237);
      run_frames(157);
      check("rally_miss_state", 32'(game_state), 3);
      check("rally_score", 32'(score), 32'(r));
      run_frames(60);
      check("rally_after_point", 32'(game_state), (r == 9) ? 32'd4 : 32'd1);
    end
    run_frames(3);
    check("gameover_state", 32'(game_state), 4);
    check("gameover_score", 32'(score), 9);

    press_start();
    run_frames(1);
    check("restart_state", 32'(game_state), 1);
    check("restart_score", 32'(score), 0);
    check_ball("restart_ball", 315, 235);

    // Left paddle moved to 420 to meet the leftward serve
    btn_l_dn = 1'b1;
    settle();
    run_frames(60);
    check("g2_launch_state", 32'(game_state), 2);
    check_ball("g2_launch_ball", 313, 237);
    check("g2_pl_280", 32'(paddle_left_y), 280);
    run_frames(35);
    check("g2_pl_420", 32'(paddle_left_y), 420);
    btn_l_dn = 1'b0;
    settle();
    run_frames(106);
    check_ball("g2_j141_ball", 31, 422);
    run_frames(1);
    check_ball("lhit_ball", 30, 420);
    check("lhit_state", 32'(game_state), 2);
    press_start();
    run_frames(1);
    check("start_ignored_state", 32'(game_state), 2);
    check_ball("lhit_next", 32, 418);
    check("g2_score", 32'(score), 0);

    // Asynchronous reset in the middle of a rally
    @(negedge iVGA_CLK);
    iRST_n = 1'b0;
    #1;
    check_ball("async_rst_ball", 315, 235);
    check("async_rst_pl", 32'(paddle_left_y), 220);
    check("async_rst_pr", 32'(paddle_right_y), 220);
    check("async_rst_state", 32'(game_state), 0);
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    settle();
    run_frames(2);
    check("post_rst_state", 32'(game_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
